prog_loader: RTL and testbench



---
 rtl/loader_pkg.sv | 54 +++++
 rtl/prog_loader_byte_asm.sv | 34 +++
 rtl/prog_loader.sv | 146 ++++++++++++++
 tb/tb_prog_loader.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared loader/core definitions: opcode map, IR field positions, loader FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package loader_pkg;

  localparam int IR_W = 32;

  // Opcode map, shared with the core's decoder
  localparam logic [4:0] OP_MOVESGPR  = 5'd0;
  localparam logic [4:0] OP_MOV       = 5'd1;
  localparam logic [4:0] OP_ADD       = 5'd2;
  localparam logic [4:0] OP_SUB       = 5'd3;
  localparam logic [4:0] OP_MUL       = 5'd4;
  localparam logic [4:0] OP_ROR       = 5'd5;
  localparam logic [4:0] OP_AND       = 5'd6;
  localparam logic [4:0] OP_XOR       = 5'd7;
  localparam logic [4:0] OP_XNOR      = 5'd8;
  localparam logic [4:0] OP_NAND      = 5'd9;
  localparam logic [4:0] OP_NOR       = 5'd10;
  localparam logic [4:0] OP_NOT       = 5'd11;
  localparam logic [4:0] OP_STOREREG  = 5'd12;
  localparam logic [4:0] OP_STOREDIN  = 5'd13;
  localparam logic [4:0] OP_SENDDOUT  = 5'd14;
  localparam logic [4:0] OP_DM_GPR    = 5'd15;
  localparam logic [4:0] MAX_OPCODE   = OP_DM_GPR;

  // IR field bit positions
  localparam int OPER_TYPE_HI = 31;
  localparam int OPER_TYPE_LO = 27;
  localparam int RDST_HI      = 26;
  localparam int RDST_LO      = 22;
  localparam int RSRC1_HI     = 21;
  localparam int RSRC1_LO     = 17;
  localparam int IMM_MODE     = 16;
  localparam int RSRC2_HI     = 15;
  localparam int RSRC2_LO     = 11;
  localparam int ISRC_HI      = 15;
  localparam int ISRC_LO      = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_BYTE  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

  // True when the IR opcode field names an instruction the core implements
  function automatic logic opcode_ok(input logic [IR_W-1:0] ir);
    return ir[OPER_TYPE_HI:OPER_TYPE_LO] <= MAX_OPCODE;
  endfunction

endpackage

// File: rtl/prog_loader_byte_asm.sv
// Packs four stream bytes into one IR word, first byte in bits 7:0.
// Latency: word valid the cycle after the 4th push; full flags the 4th push combinationally.
// Backpressure: none internally; push only when a byte is actually transferred.
module byte_asm
  import loader_pkg::*;
(
  input  logic            clk,
  input  logic            sys_rst_n,
  input  logic            clr,
  input  logic            push,
  input  logic [7:0]      din,
  output logic [IR_W-1:0] word,
  output logic            full
);

  logic [1:0] cnt;

  // Shift each new byte in from the top so byte 0 ends up in the low lane
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt  <= 2'd0;
      word <= '0;
    end else if (clr) begin
      cnt  <= 2'd0;
      word <= '0;
    end else if (push) begin
      cnt  <= cnt + 2'd1;
      word <= {din, word[IR_W-1:8]};
    end
  end

  assign full = push && (cnt == 2'd3);

endmodule

// File: rtl/prog_loader.sv
// Loads a length-prefixed byte stream into instruction memory, holding the core meanwhile.
// Latency: imem write one cycle after the 4th byte of each word; OPCODE_CHECK_EN rejects bad opcodes.
// Backpressure: rx_ready high only in LEN/BYTE; stalls on rx_valid low indefinitely.
module prog_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              sys_rst_n,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_cnt
);

  generate
    if (DATA_W != 32) begin : g_bad_data_w
      $error("prog_loader: DATA_W must be 32");
    end
  endgenerate

  localparam logic [31:0] DEPTH = 32'(1) << ADDR_W;

  state_t          state, state_nxt;
  logic [ADDR_W:0] n_words;
  logic [ADDR_W:0] cnt_plus1;
  logic [IR_W-1:0] asm_word;
  logic            asm_full, asm_clr, asm_push;
  logic            xfer, bad_n, op_ok;
  logic            load_n, cnt_clr, cnt_inc;

  assign xfer      = rx_valid && rx_ready;
  assign asm_push  = xfer && (state == ST_BYTE);
  assign bad_n     = (rx_data == 8'd0) || ({24'd0, rx_data} > DEPTH);
  assign cnt_plus1 = word_cnt + 1'b1;

  byte_asm u_asm (
    .clk       (clk),
    .sys_rst_n (sys_rst_n),
    .clr       (asm_clr),
    .push      (asm_push),
    .din       (rx_data),
    .word      (asm_word),
    .full      (asm_full)
  );

  // State, word count and target length registers
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= ST_IDLE;
      n_words  <= '0;
      word_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (load_n)       n_words  <= rx_data[ADDR_W:0];
      if (cnt_clr)      word_cnt <= '0;
      else if (cnt_inc) word_cnt <= cnt_plus1;
    end
  end

  // Next state and per-state outputs
  always_comb begin
    state_nxt = state;
    rx_ready  = 1'b0;
    imem_we   = 1'b0;
    cpu_hold  = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    asm_clr   = 1'b0;
    load_n    = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
`ifdef OPCODE_CHECK_EN
    op_ok     = opcode_ok(asm_word);
`else
    op_ok     = 1'b1;
`endif
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_LEN;
          cnt_clr   = 1'b1;
          asm_clr   = 1'b1;
        end
      end
      ST_LEN: begin
        rx_ready = 1'b1;
        cpu_hold = 1'b1;
        if (xfer) begin
          if (bad_n) begin
            state_nxt = ST_ERR;
          end else begin
            load_n    = 1'b1;
            state_nxt = ST_BYTE;
          end
        end
      end
      ST_BYTE: begin
        rx_ready = 1'b1;
        cpu_hold = 1'b1;
        if (asm_full) state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        cpu_hold = 1'b1;
        if (op_ok) begin
          imem_we   = 1'b1;
          cnt_inc   = 1'b1;
          state_nxt = (cnt_plus1 < n_words) ? ST_BYTE : ST_DONE;
        end else begin
          state_nxt = ST_ERR;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          state_nxt = ST_LEN;
          cnt_clr   = 1'b1;
          asm_clr   = 1'b1;
        end
      end
      ST_ERR: begin
        err      = 1'b1;
        cpu_hold = 1'b1;
        if (start) begin
          state_nxt = ST_LEN;
          cnt_clr   = 1'b1;
          asm_clr   = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign imem_addr  = word_cnt[ADDR_W-1:0];
  assign imem_wdata = asm_word;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed table, reset/start corner cases, random loads.
// Latency: n/a.
// Backpressure: the driver inserts idle cycles on rx_valid.
module tb_prog_loader;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;
`ifdef OPCODE_CHECK_EN
  localparam bit OPCHK = 1'b1;
`else
  localparam bit OPCHK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              sys_rst_n;
  logic              start;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   word_cnt;

  always #5 clk = ~clk;

  prog_loader #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk        (clk),
    .sys_rst_n  (sys_rst_n),
    .start      (start),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err),
    .word_cnt   (word_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Observed instruction-memory writes
  logic [ADDR_W-1:0] wa_q[$];
  logic [31:0]       wd_q[$];

  always @(negedge clk) begin
    if (sys_rst_n && imem_we) begin
      wa_q.push_back(imem_addr);
      wd_q.push_back(imem_wdata);
      chk("rx_ready_low_in_write", {63'd0, rx_ready}, 64'd0);
    end
  end

  // Reference model results
  int          exp_a[$];
  logic [31:0] exp_d[$];
  bit          m_done, m_err;
  int          m_wcnt, m_nbytes;

  task automatic model(input int n, input logic [31:0] words[$]);
    exp_a.delete();
    exp_d.delete();
    m_done = 0; m_err = 0; m_wcnt = 0; m_nbytes = 0;
    if (n == 0 || n > DEPTH) begin
      m_err = 1;
      return;
    end
    for (int i = 0; i < n; i++) begin
      m_nbytes = 4 * (i + 1);
      if (OPCHK && (words[i] >> 27) > 15) begin
        m_err  = 1;
        m_wcnt = i;
        return;
      end
      exp_a.push_back(i);
      exp_d.push_back(words[i]);
    end
    m_done = 1;
    m_wcnt = n;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offer one byte after a gap; gap < 0 picks a random gap of 0..2 cycles
  task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
    int g;
    ok = 0;
    g = (gap < 0) ? int'($urandom_range(2)) : gap;
    rx_valid = 1'b0;
    for (int i = 0; i < g; i++) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    for (int t = 0; t < 50; t++) begin
      if (rx_ready) begin
        @(negedge clk);
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    rx_valid = 1'b0;
  endtask

  task automatic run_load(input string tag, input int n, input logic [31:0] words[$],
                          input int gap, input int mid_start,
                          input bit e_done, input bit e_err, input int e_wcnt);
    bit          ok;
    logic [31:0] w;
    model(n, words);
    wa_q.delete();
    wd_q.delete();
    pulse_start();
    chk($sformatf("%s_start_clears_err", tag), {63'd0, err}, 64'd0);
    chk($sformatf("%s_start_clears_done", tag), {63'd0, done}, 64'd0);
    chk($sformatf("%s_start_clears_wcnt", tag), 64'(word_cnt), 64'd0);
    send_byte(8'(n), gap, ok);
    if (!ok) begin
      chk($sformatf("%s_len_timeout", tag), 64'd0, 64'd1);
      return;
    end
    for (int i = 0; i < m_nbytes; i++) begin
      w = words[i / 4];
      if (i == mid_start) pulse_start();
      send_byte(8'(w >> (8 * (i % 4))), gap, ok);
      if (!ok) begin
        chk($sformatf("%s_byte%0d_timeout", tag, i), 64'd0, 64'd1);
        return;
      end
    end
    for (int t = 0; t < 20; t++) begin
      if (done || err) break;
      @(negedge clk);
    end
    @(negedge clk);
    chk($sformatf("%s_done", tag), {63'd0, done}, {63'd0, e_done});
    chk($sformatf("%s_err", tag), {63'd0, err}, {63'd0, e_err});
    chk($sformatf("%s_word_cnt", tag), 64'(word_cnt), 64'(e_wcnt));
    chk($sformatf("%s_cpu_hold", tag), {63'd0, cpu_hold}, {63'd0, e_err});
    chk($sformatf("%s_nwrites", tag), 64'(wa_q.size()), 64'(exp_a.size()));
    for (int i = 0; i < exp_a.size() && i < wa_q.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), 64'(wa_q[i]), 64'(exp_a[i]));
      chk($sformatf("%s_data%0d", tag, i), 64'(wd_q[i]), 64'(exp_d[i]));
    end
  endtask

  typedef struct {
    string             name;
    int                n;
    logic [15:0][31:0] w;
    int                gap;
    int                mid;
    bit                e_done;
    bit                e_err;
    int                e_wcnt;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] wq[$];
    bit          ok;
    int          n;
    logic [31:0] w;

    sys_rst_n = 1'b0;
    start     = 1'b0;
    rx_data   = 8'd0;
    rx_valid  = 1'b0;

    // Directed table: name, N, words, gap, mid-load start byte, done, err, word_cnt
    vecs[0] = '{"basic",    2,  '0, 0, -1, 1'b1, 1'b0, 2};
    vecs[1] = '{"toggle",   2,  '0, 1, -1, 1'b1, 1'b0, 2};
    vecs[2] = '{"n0",       0,  '0, 0, -1, 1'b0, 1'b1, 0};
    vecs[3] = '{"n17",      17, '0, 0, -1, 1'b0, 1'b1, 0};
    vecs[4] = '{"badop",    2,  '0, 0, -1, !OPCHK, OPCHK, OPCHK ? 1 : 2};
    vecs[5] = '{"midstart", 2,  '0, 0, 3,  1'b1, 1'b0, 2};
    vecs[6] = '{"full16",   16, '0, 0, -1, 1'b1, 1'b0, 16};
    for (int v = 0; v < 6; v++) begin
      vecs[v].w[0] = 32'h0841_0000;
      vecs[v].w[1] = 32'h1001_001E;
    end
    vecs[4].w[1] = 32'hF800_0000;
    for (int i = 0; i < 16; i++) vecs[6].w[i] = 32'h0000_0101 * (i + 1) + (i << 27);

    #1;
    chk("rst_rx_ready", {63'd0, rx_ready}, 64'd0);
    chk("rst_imem_we", {63'd0, imem_we}, 64'd0);
    chk("rst_cpu_hold", {63'd0, cpu_hold}, 64'd0);
    chk("rst_done_err", {62'd0, done, err}, 64'd0);
    chk("rst_word_cnt", 64'(word_cnt), 64'd0);
    chk("rst_addr_wdata", {28'd0, imem_addr, imem_wdata}, 64'd0);
    @(negedge clk);
    sys_rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      wq.delete();
      for (int i = 0; i < 16; i++) wq.push_back(vecs[v].w[i]);
      run_load(vecs[v].name, vecs[v].n, wq, vecs[v].gap, vecs[v].mid,
               vecs[v].e_done, vecs[v].e_err, vecs[v].e_wcnt);
    end

    // Asynchronous reset in the middle of a load, then a clean restart
    pulse_start();
    send_byte(8'd3, 0, ok);
    for (int i = 0; i < 6; i++) send_byte(8'(8'h11 * (i + 1)), 0, ok);
    chk("pre_reset_ok", {63'd0, ok}, 64'd1);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("midrst_rx_ready", {63'd0, rx_ready}, 64'd0);
    chk("midrst_hold_done_err_we", {60'd0, cpu_hold, done, err, imem_we}, 64'd0);
    chk("midrst_word_cnt", 64'(word_cnt), 64'd0);
    chk("midrst_addr_wdata", {28'd0, imem_addr, imem_wdata}, 64'd0);
    @(negedge clk);
    sys_rst_n = 1'b1;
    @(negedge clk);
    wq.delete();
    wq.push_back(32'h0DCC_BBAA);
    run_load("rst_restart", 1, wq, 0, -1, 1'b1, 1'b0, 1);

    // Random loads against the reference model
    for (int r = 0; r < 25; r++) begin
      n = ($urandom_range(4) == 0) ? int'($urandom_range(18)) : int'($urandom_range(16, 1));
      wq.delete();
      for (int i = 0; i < 16; i++) begin
        w = $urandom;
        if ($urandom_range(3) != 0) w[31:27] = 5'($urandom_range(15));
        wq.push_back(w);
      end
      model(n, wq);
      run_load($sformatf("rnd%0d", r), n, wq, -1, -1, m_done, m_err, m_wcnt);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
